// File: rtl/fft_sdf_ctrl_pkg.sv
// fft_pkg: shared sizes, stage-mode encodings, FSM states and bit-reverse helper for the SDF FFT controller
package fft_pkg;
  localparam int LOG2N = 8;
  localparam int N = 1 << LOG2N;
  localparam int TWW = LOG2N - 1;
  localparam logic [LOG2N-1:0] FMAX = '1;
  localparam logic [LOG2N-1:0] FPEN = FMAX - 1'b1;
  localparam logic [1:0] MODE_FILL = 2'd0;
  localparam logic [1:0] MODE_LOAD = 2'd1;
  localparam logic [1:0] MODE_BF = 2'd2;
  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;
  function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_sdf_ctrl_if.sv
// fft_sdf_ctrl_if: handshake and schedule bus between the FFT pipeline (master) and its sequencer (slave)
// master drives in_valid/flush; slave returns zero_ins, adv, stage_mode, tw_idx, out_valid, out_first, out_idx_rev, busy
interface fft_sdf_ctrl_if;
  import fft_pkg::*;
  logic in_valid, flush, zero_ins, adv, out_valid, out_first, busy;
  logic [2*LOG2N-1:0] stage_mode;
  logic [TWW*LOG2N-1:0] tw_idx;
  logic [LOG2N-1:0] out_idx_rev;
  modport master (output in_valid, flush,
                  input zero_ins, adv, stage_mode, tw_idx, out_valid, out_first, out_idx_rev, busy);
  modport slave (input in_valid, flush,
                 output zero_ins, adv, stage_mode, tw_idx, out_valid, out_first, out_idx_rev, busy);
endinterface

// File: rtl/fft_sdf_ctrl_sched.sv
// fft_stage_sched: maps global count g and fill count f to one stage's mode and twiddle index
// g_i/f_i: global and fill counters; mode_o: fill/load/butterfly; tw_o: twiddle ROM index
module fft_stage_sched
  import fft_pkg::*;
#(
  parameter int K = 0
) (
  input  logic [LOG2N-1:0] g_i,
  input  logic [LOG2N-1:0] f_i,
  output logic [1:0]       mode_o,
  output logic [TWW-1:0]   tw_o
);
  localparam int H = N >> (K + 1);
  localparam logic [LOG2N-1:0] HMASK = LOG2N'(H - 1);
  localparam logic [LOG2N-1:0] PRIME = LOG2N'(N - H);
  // upstream delay is a multiple of 2H, so the local count is just the low bits of g
  always_comb begin
    mode_o = (f_i < PRIME) ? MODE_FILL : g_i[LOG2N-1-K] ? MODE_BF : MODE_LOAD;
    tw_o = (mode_o == MODE_BF) ? TWW'((g_i & HMASK) << K) : '0;
  end
endmodule

// File: rtl/fft_sdf_ctrl.sv
// fft_sdf_ctrl: central sequencer for the 256-point radix-2 SDF FFT (stage schedule, output tagging, drain)
// clk/rst_n: clock and async active-low reset; ctl: slave side of fft_sdf_ctrl_if
module fft_sdf_ctrl
  import fft_pkg::*;
(
  input logic clk,
  input logic rst_n,
  fft_sdf_ctrl_if.slave ctl
);
  state_t state_q, state_d;
  logic [LOG2N-1:0] g_q, g_d, f_q, f_d, p_q, p_d, d_q, d_d;
  logic pend_q, pend_d, active, drain, adv, ov, start_drain, abort, last_drain;
  logic [2*LOG2N-1:0] mode;
  logic [TWW*LOG2N-1:0] tw;
  for (genvar k = 0; k < LOG2N; k++) begin : g_st
    fft_stage_sched #(.K(k)) u_sched (
      .g_i    (g_q),
      .f_i    (f_q),
      .mode_o (mode[2*k +: 2]),
      .tw_o   (tw[TWW*k +: TWW])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      g_q <= '0;
      f_q <= '0;
      p_q <= '0;
      d_q <= '0;
      pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q <= g_d;
      f_q <= f_d;
      p_q <= p_d;
      d_q <= d_d;
      pend_q <= pend_d;
    end
  end
  always_comb begin
    g_d = last_drain ? '0 : adv ? g_q + 1'b1 : g_q;
    f_d = last_drain ? '0 : (adv && f_q != FMAX) ? f_q + 1'b1 : f_q;
    p_d = last_drain ? '0 : ov ? p_q + 1'b1 : p_q;
    d_d = (drain && !ctl.in_valid && !last_drain) ? d_q + 1'b1 : '0;
    // a request seen in IDLE or DRAIN is dropped; a pending one is consumed on drain entry
    pend_d = active & (pend_q | ctl.flush) & ~start_drain;
    case (state_q)
      IDLE:    state_d = ctl.in_valid ? FILL : IDLE;
      FILL:    state_d = start_drain ? DRAIN : (adv && f_q == FPEN) ? RUN : FILL;
      RUN:     state_d = start_drain ? DRAIN : RUN;
      default: state_d = abort ? ((f_d == FMAX) ? RUN : FILL) : last_drain ? IDLE : DRAIN;
    endcase
  end
  always_comb begin
    active = state_q == FILL || state_q == RUN;
    drain = state_q == DRAIN;
    adv = ctl.in_valid | drain;
    ov = adv & (f_q == FMAX);
    start_drain = active & pend_q & ~ctl.in_valid;
    abort = drain & ctl.in_valid;
    last_drain = drain & ~ctl.in_valid & (d_q == FPEN);
    ctl.zero_ins = drain & ~ctl.in_valid;
    ctl.adv = adv;
    ctl.out_valid = ov;
    ctl.out_first = ov & (p_q == '0);
    ctl.out_idx_rev = bit_rev(p_q);
    ctl.busy = state_q != IDLE;
    ctl.stage_mode = mode;
    ctl.tw_idx = tw;
  end
endmodule

// File: tb/tb_fft_sdf_ctrl.sv
// tb_fft_sdf_ctrl: directed vector bench for the SDF FFT sequencer
module tb_fft_sdf_ctrl;
  logic clk, rst_n;
  int checks = 0, failures = 0, acc = 0, outs = 0;
  fft_sdf_ctrl_if bus ();
  fft_sdf_ctrl dut (.clk(clk), .rst_n(rst_n), .ctl(bus));
  typedef struct {bit iv; bit fl; bit adv; bit zi; bit ov; bit busy; logic [15:0] sm;} vec_t;
  vec_t tbl[6];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic int rev8(input int v);
    int r = 0;
    for (int i = 0; i < 8; i++) if (v[i]) r |= 1 << (7 - i);
    return r;
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (acc=%0d outs=%0d t=%0t)", nm, act, exp, acc, outs, $time);
    end
  endtask
  // one cycle: iv/fl drive the inputs, dr says a drain advance is expected this cycle
  task automatic cyc(input bit iv, input bit fl, input bit dr);
    int fe;
    bit ov;
    bus.in_valid = iv;
    bus.flush = fl;
    @(negedge clk);
    fe = acc > 255 ? 255 : acc;
    ov = (iv | dr) && fe == 255;
    chk("adv", bus.adv, iv | dr);
    chk("zero_ins", bus.zero_ins, dr & ~iv);
    chk("out_valid", bus.out_valid, ov);
    chk("out_first", bus.out_first, ov && outs % 256 == 0);
    if (ov) chk("out_idx_rev", bus.out_idx_rev, rev8(outs % 256));
    chk("s0_primed", bus.stage_mode[1:0] != 0, fe >= 128);
    chk("s2_primed", bus.stage_mode[5:4] != 0, fe >= 224);
    if (fe == 255) chk("s7_mode", bus.stage_mode[15:14], acc % 2 ? 2 : 1);
    if (fe == 255 && acc % 256 == 27) begin
      chk("s3_mode", bus.stage_mode[7:6], 2);
      chk("s3_tw", bus.tw_idx[27:21], 88);
    end
    @(posedge clk);
    #1;
    if (iv | dr) begin
      if (ov) outs++;
      acc++;
    end
  endtask
  initial begin
    tbl[0] = '{iv: 0, fl: 1, adv: 0, zi: 0, ov: 0, busy: 0, sm: 16'h0};
    tbl[1] = '{iv: 0, fl: 0, adv: 0, zi: 0, ov: 0, busy: 0, sm: 16'h0};
    tbl[2] = '{iv: 1, fl: 0, adv: 1, zi: 0, ov: 0, busy: 0, sm: 16'h0};
    tbl[3] = '{iv: 0, fl: 0, adv: 0, zi: 0, ov: 0, busy: 1, sm: 16'h0};
    tbl[4] = '{iv: 1, fl: 0, adv: 1, zi: 0, ov: 0, busy: 1, sm: 16'h0};
    tbl[5] = '{iv: 1, fl: 0, adv: 1, zi: 0, ov: 0, busy: 1, sm: 16'h0};
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_adv", bus.adv, 0);
    chk("rst_zero_ins", bus.zero_ins, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_first", bus.out_first, 0);
    chk("rst_stage_mode", bus.stage_mode, 0);
    chk("rst_tw_zero", bus.tw_idx == '0, 1);
    chk("rst_out_idx_rev", bus.out_idx_rev, 0);
    rst_n = 1'b1;
    // startup vectors: flush in IDLE is ignored, gaps stall
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = tbl[i].iv;
      bus.flush = tbl[i].fl;
      @(negedge clk);
      chk("tbl_adv", bus.adv, tbl[i].adv);
      chk("tbl_zero_ins", bus.zero_ins, tbl[i].zi);
      chk("tbl_out_valid", bus.out_valid, tbl[i].ov);
      chk("tbl_busy", bus.busy, tbl[i].busy);
      chk("tbl_stage_mode", bus.stage_mode, tbl[i].sm);
      @(posedge clk);
      #1;
      if (tbl[i].iv) acc++;
    end
    // three contiguous frames
    while (acc < 768) cyc(1, 0, 0);
    chk("frames_outs", outs, 513);
    // flush with in_valid low: pend latched, drain next cycle, 255 zero cycles
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("pre_drain_busy", bus.busy, 1);
    repeat (255) cyc(0, 0, 1);
    acc = 0;
    outs = 0;
    chk("post_drain_busy", bus.busy, 0);
    chk("post_drain_idx", bus.out_idx_rev, 0);
    chk("post_drain_mode", bus.stage_mode, 0);
    chk("post_drain_tw_zero", bus.tw_idx == '0, 1);
    cyc(0, 0, 0);
    // flush coincident with in_valid, then drain aborted at drain cycle 100
    while (acc < 300) cyc(1, 0, 0);
    cyc(1, 1, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    repeat (100) cyc(0, 0, 1);
    cyc(1, 0, 1);
    cyc(0, 0, 0);
    chk("abort_busy", bus.busy, 1);
    repeat (5) cyc(1, 0, 0);
    // async reset mid-RUN, no clock edge needed
    bus.in_valid = 1'b0;
    chk("pre_rst_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_stage_mode", bus.stage_mode, 0);
    chk("arst_tw_zero", bus.tw_idx == '0, 1);
    chk("arst_idx", bus.out_idx_rev, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    acc = 0;
    outs = 0;
    // ~30% idle gaps: same output index sequence as the contiguous run
    for (int i = 0; i < 3000 && acc < 778; i++) cyc($urandom_range(0, 99) >= 30, 0, 0);
    chk("gap_acc", acc, 778);
    chk("gap_outs", outs, acc - 255);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
